uart_tx_buffered: RTL and testbench



---
 rtl/uart_tx_buffered.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: valid/ready write port into a small FIFO, drained
// by a start/data/parity/stop serializer with its own bit timer.
module uart_tx_buffered #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int TIMER_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;

    localparam logic [TIMER_W-1:0] BIT_LOAD  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]         LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]         LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic                 push;
    logic                 pop;
    logic                 load;
    logic [DATA_BITS-1:0] head;

    // A write is only taken against the registered ready, so a full FIFO
    // refuses it even on the edge where a pop frees a slot.
    assign push = valid_in && ready_q;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        load      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (count_q != '0) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (timer_q == '0) begin
                    state_d   = S_DATA;
                    timer_d   = BIT_LOAD;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_DATA: begin
                if (timer_q == '0) begin
                    timer_d = BIT_LOAD;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_PARITY: begin
                if (timer_q == '0) begin
                    state_d   = S_STOP;
                    timer_d   = BIT_LOAD;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_STOP: begin
                if (timer_q == '0) begin
                    if (bit_idx_q != LAST_STOP) begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        timer_d   = BIT_LOAD;
                    end else if (count_q != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Loading the head word is shared by IDLE and the back-to-back STOP exit.
        if (load) begin
            state_d   = S_START;
            timer_d   = BIT_LOAD;
            bit_idx_d = '0;
            shift_d   = head;
            parity_d  = (^head) ^ (PARITY == 2);
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end
    end

    always_comb begin
        pop      = load;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        ready_d  = (count_d != FULL_CNT);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign ready_out  = ready_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three instances (no parity, even, odd with two
// stop bits) checked against a byte scoreboard and a bit-level frame model.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] data0, data1, data2;
    logic       valid0, valid1, valid2;
    logic       ready0, ready1, ready2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic [2:0] count0, count1, count2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1),
                       .PARITY(0), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .n_rst(n_rst), .data_in(data0), .valid_in(valid0),
        .ready_out(ready0), .tx(tx0), .busy(busy0), .fifo_count(count0));

    uart_tx_buffered #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1),
                       .PARITY(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .n_rst(n_rst), .data_in(data1), .valid_in(valid1),
        .ready_out(ready1), .tx(tx1), .busy(busy1), .fifo_count(count1));

    uart_tx_buffered #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(2),
                       .PARITY(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .n_rst(n_rst), .data_in(data2), .valid_in(valid2),
        .ready_out(ready2), .tx(tx2), .busy(busy2), .fifo_count(count2));

    // {ready, busy, tx, count[2:0]} of the selected instance
    function automatic logic [5:0] outs(input int inst);
        case (inst)
            0:       return {ready0, busy0, tx0, count0};
            1:       return {ready1, busy1, tx1, count1};
            default: return {ready2, busy2, tx2, count2};
        endcase
    endfunction

    task automatic drive(input int inst, input logic [7:0] d, input logic v);
        case (inst)
            0:       begin data0 = d; valid0 = v; end
            1:       begin data1 = d; valid1 = v; end
            default: begin data2 = d; valid2 = v; end
        endcase
    endtask

    task automatic push_exp(input int inst, input logic [7:0] d);
        case (inst)
            0:       exp_q0.push_back(d);
            1:       exp_q1.push_back(d);
            default: exp_q2.push_back(d);
        endcase
    endtask

    // Called on the negedge inside the first start-bit cycle; returns on the
    // negedge of the first cycle after the last stop bit.
    task automatic check_frame(input int inst);
        logic [7:0]  exp_b;
        logic [11:0] bits;
        logic [11:0] rx;
        logic [5:0]  o;
        logic        exp_par;
        int          par, stops, nb, hold_err, busy_err, sz;
        par   = (inst == 0) ? 0 : ((inst == 1) ? 1 : 2);
        stops = (inst == 2) ? 2 : 1;
        case (inst)
            0:       sz = exp_q0.size();
            1:       sz = exp_q1.size();
            default: sz = exp_q2.size();
        endcase
        n_checks++;
        if (sz == 0) begin
            n_fail++;
            $display("FAIL frame_scoreboard inst%0d: got empty queue, required a pending byte", inst);
            return;
        end
        case (inst)
            0:       exp_b = exp_q0.pop_front();
            1:       exp_b = exp_q1.pop_front();
            default: exp_b = exp_q2.pop_front();
        endcase
        exp_par = (par == 1) ? (^exp_b) : ~(^exp_b);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = exp_b[i];
        nb = 9;
        if (par != 0) begin
            bits[nb] = exp_par;
            nb++;
        end
        nb += stops;
        rx = '0;
        hold_err = 0;
        busy_err = 0;
        for (int j = 0; j < nb; j++) begin
            for (int c = 0; c < 10; c++) begin
                o = outs(inst);
                if (o[3] !== bits[j]) hold_err++;
                if (o[4] !== 1'b1) busy_err++;
                if (c == 5) rx[j] = o[3];
                @(negedge clk);
            end
        end
        n_checks++;
        if (rx[8:1] !== exp_b) begin
            n_fail++;
            $display("FAIL rx_byte inst%0d: got %02h required %02h", inst, rx[8:1], exp_b);
        end
        n_checks++;
        if (hold_err !== 0) begin
            n_fail++;
            $display("FAIL bit_hold inst%0d byte %02h: got %0d wrong tx cycles required 0", inst, exp_b, hold_err);
        end
        n_checks++;
        if (busy_err !== 0) begin
            n_fail++;
            $display("FAIL busy_frame inst%0d byte %02h: got %0d cycles with busy=0 required 0", inst, exp_b, busy_err);
        end
        if (par != 0) begin
            n_checks++;
            if (rx[9] !== exp_par) begin
                n_fail++;
                $display("FAIL parity_bit inst%0d byte %02h: got %b required %b", inst, exp_b, rx[9], exp_par);
            end
        end
    endtask

    task automatic test_reset();
        logic [5:0] o;
        n_rst = 1'b0;
        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        drive(2, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            for (int inst = 0; inst < 3; inst++) begin
                o = outs(inst);
                n_checks++;
                if (o[3] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_tx inst%0d pass%0d: got %b required 1", inst, pass, o[3]);
                end
                n_checks++;
                if (o[5] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_ready inst%0d pass%0d: got %b required 1", inst, pass, o[5]);
                end
                n_checks++;
                if (o[4] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_busy inst%0d pass%0d: got %b required 0", inst, pass, o[4]);
                end
                n_checks++;
                if (o[2:0] !== 3'd0) begin
                    n_fail++;
                    $display("FAIL reset_count inst%0d pass%0d: got %0d required 0", inst, pass, o[2:0]);
                end
            end
            if (pass == 0) begin
                n_rst = 1'b1;
                repeat (4) @(negedge clk);
            end
        end
    endtask

    task automatic test_single(input int inst, input logic [7:0] b);
        logic [5:0] o;
        o = outs(inst);
        n_checks++;
        if (o[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready inst%0d: got %b required 1", inst, o[5]);
        end
        drive(inst, b, 1'b1);
        push_exp(inst, b);
        @(negedge clk);
        drive(inst, 8'h00, 1'b0);
        o = outs(inst);
        n_checks++;
        if (o[2:0] !== 3'd1 || o[3] !== 1'b1 || o[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept inst%0d: got count=%0d tx=%b busy=%b required count=1 tx=1 busy=0",
                     inst, o[2:0], o[3], o[4]);
        end
        @(negedge clk);
        o = outs(inst);
        n_checks++;
        if (o[2:0] !== 3'd0 || o[3] !== 1'b0 || o[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_start inst%0d: got count=%0d tx=%b busy=%b required count=0 tx=0 busy=1",
                     inst, o[2:0], o[3], o[4]);
        end
        check_frame(inst);
        o = outs(inst);
        n_checks++;
        if (o[3] !== 1'b1 || o[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle_after inst%0d: got tx=%b busy=%b required tx=1 busy=0", inst, o[3], o[4]);
        end
    endtask

    task automatic test_back_to_back();
        fork
            begin
                int         i   = 0;
                int         cyc = 0;
                logic       r;
                while (i < 6 && cyc < 400) begin
                    data0  = 8'(i + 1);
                    valid0 = 1'b1;
                    r      = ready0;
                    @(negedge clk);
                    cyc++;
                    if (r) begin
                        exp_q0.push_back(8'(i + 1));
                        i++;
                        if (i == 5) begin
                            n_checks++;
                            if (ready0 !== 1'b0 || count0 !== 3'd4) begin
                                n_fail++;
                                $display("FAIL b2b_full: got ready=%b count=%0d required ready=0 count=4",
                                         ready0, count0);
                            end
                        end
                    end
                end
                valid0 = 1'b0;
                n_checks++;
                if (i !== 6) begin
                    n_fail++;
                    $display("FAIL b2b_accepted: got %0d bytes required 6", i);
                end
            end
            begin
                int wait_cyc = 0;
                while (tx0 !== 1'b0 && wait_cyc < 20) begin
                    @(negedge clk);
                    wait_cyc++;
                end
                n_checks++;
                if (wait_cyc !== 2) begin
                    n_fail++;
                    $display("FAIL b2b_first_pop: got start after %0d cycles required 2", wait_cyc);
                end
                for (int n = 0; n < 6; n++) check_frame(0);
                n_checks++;
                if (tx0 !== 1'b1 || busy0 !== 1'b0 || count0 !== 3'd0) begin
                    n_fail++;
                    $display("FAIL b2b_drained: got tx=%b busy=%b count=%0d required tx=1 busy=0 count=0",
                             tx0, busy0, count0);
                end
            end
        join
    endtask

    task automatic test_simul_push_pop();
        drive(0, 8'h11, 1'b1);
        exp_q0.push_back(8'h11);
        @(negedge clk);
        drive(0, 8'h22, 1'b1);
        exp_q0.push_back(8'h22);
        @(negedge clk);
        fork
            check_frame(0);
            begin
                drive(0, 8'h33, 1'b1);
                exp_q0.push_back(8'h33);
                @(negedge clk);
                drive(0, 8'h00, 1'b0);
                repeat (98) @(negedge clk);
                n_checks++;
                if (count0 !== 3'd2 || tx0 !== 1'b1 || ready0 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL simul_before: got count=%0d tx=%b ready=%b required count=2 tx=1 ready=1",
                             count0, tx0, ready0);
                end
                drive(0, 8'h44, 1'b1);
                exp_q0.push_back(8'h44);
                @(negedge clk);
                drive(0, 8'h00, 1'b0);
                n_checks++;
                if (count0 !== 3'd2 || tx0 !== 1'b0 || busy0 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL simul_edge: got count=%0d tx=%b busy=%b required count=2 tx=0 busy=1",
                             count0, tx0, busy0);
                end
            end
        join
        for (int n = 0; n < 3; n++) check_frame(0);
        n_checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || count0 !== 3'd0) begin
            n_fail++;
            $display("FAIL simul_drained: got tx=%b busy=%b count=%0d required tx=1 busy=0 count=0",
                     tx0, busy0, count0);
        end
    endtask

    task automatic test_reset_mid_frame();
        drive(0, 8'h00, 1'b1);
        @(negedge clk);
        drive(0, 8'h77, 1'b1);
        @(negedge clk);
        drive(0, 8'h00, 1'b0);
        repeat (44) @(negedge clk);
        n_checks++;
        if (tx0 !== 1'b0 || count0 !== 3'd1 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_pre: got tx=%b count=%0d busy=%b required tx=0 count=1 busy=1",
                     tx0, count0, busy0);
        end
        #2 n_rst = 1'b0;
        #1;
        n_checks++;
        if (tx0 !== 1'b1 || count0 !== 3'd0 || busy0 !== 1'b0 || ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_async: got tx=%b count=%0d busy=%b ready=%b required 1,0,0,1",
                     tx0, count0, busy0, ready0);
        end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || count0 !== 3'd0) begin
            n_fail++;
            $display("FAIL midframe_discard: got tx=%b busy=%b count=%0d required tx=1 busy=0 count=0",
                     tx0, busy0, count0);
        end
        test_single(0, 8'h3C);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single(0, 8'hA5);
        test_single(1, 8'hA5);
        test_single(2, 8'hA5);
        test_single(1, 8'h07);
        test_back_to_back();
        test_simul_push_pop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
